// File: rtl/pio_counter_bank.sv
// Multi-channel up/down counter bank on the host PIO register port.
// Each channel has its own step, limit, wrap/stop mode, snapshot and sticky done flag.
package pio_counter_pkg;
  typedef struct packed {
    logic        we;
    logic [2:0]  off;
    logic [31:0] wdata;
  } ch_req_t;
endpackage

module pio_counter_ch #(
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  pio_counter_pkg::ch_req_t req,
  input  logic                     gen,
  input  logic                     done_clr,
  output logic [WIDTH-1:0]         cnt,
  output logic                     done,
  output logic [31:0]              rdata
);
  // Wide enough that neither a 32-bit step nor count+step can overflow.
  localparam int SW = (WIDTH > 32 ? WIDTH : 32) + 1;

  logic             en, dir, mode, clr, term;
  logic [WIDTH-1:0] limit, snap, cnt_nxt;
  logic [31:0]      step;
  logic [SW-1:0]    cnt_x, lim_x, step_x, sum;
  logic [63:0]      lim64, snap64;

  assign clr    = req.we && (req.off == 3'd0) && req.wdata[3];
  assign lim64  = 64'(limit);
  assign snap64 = 64'(snap);

  always_comb begin
    cnt_x   = SW'(cnt);
    lim_x   = SW'(limit);
    step_x  = SW'(step);
    sum     = cnt_x + step_x;
    term    = 1'b0;
    cnt_nxt = cnt;
    if (gen && en) begin
      if (!dir) begin
        if (cnt >= limit) begin
          term    = 1'b1;
          cnt_nxt = mode ? cnt : '0;
        end else begin
          cnt_nxt = (sum > lim_x) ? limit : WIDTH'(sum);
        end
      end else begin
        if (cnt == '0) begin
          term    = 1'b1;
          cnt_nxt = mode ? cnt : limit;
        end else begin
          cnt_nxt = (cnt_x < step_x) ? '0 : WIDTH'(cnt_x - step_x);
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (req.off)
      3'd0:    rdata = {29'b0, mode, dir, en};
      3'd1:    rdata = lim64[31:0];
      3'd2:    rdata = lim64[63:32];
      3'd3:    rdata = step;
      3'd5:    rdata = snap64[31:0];
      3'd6:    rdata = snap64[63:32];
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      snap  <= '0;
      done  <= 1'b0;
      en    <= 1'b1;
      dir   <= 1'b0;
      mode  <= 1'b0;
      limit <= '1;
      step  <= 32'd1;
    end else begin
      cnt <= clr ? '0 : cnt_nxt;
      // A terminal event in the same cycle as a W1C keeps the flag set.
      if (term && !clr)  done <= 1'b1;
      else if (done_clr) done <= 1'b0;
      if (req.we) begin
        case (req.off)
          3'd0:    {mode, dir, en} <= req.wdata[2:0];
          3'd1:    limit <= WIDTH'({lim64[63:32], req.wdata});
          3'd2:    limit <= WIDTH'({req.wdata, lim64[31:0]});
          3'd3:    step  <= req.wdata;
          3'd4:    snap  <= cnt;
          default: ;
        endcase
      end
    end
  end
endmodule

module pio_counter_bank #(
  parameter int          WIDTH   = 64,
  parameter int          NUM_CH  = 4,
  parameter int          LED_BIT = 26,
  parameter logic [31:0] SERIAL  = 32'h0022_1103
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pio_hwen,
  input  logic [31:0]                    pio_addr,
  input  logic [31:0]                    pio_wdata,
  output logic [31:0]                    pio_rdata,
  output logic [NUM_CH-1:0][WIDTH-1:0]   count,
  output logic                           finished,
  output logic                           led,
  output logic [31:0]                    design_serial_number
);
  logic                          gen;
  logic [NUM_CH-1:0]             done, sel;
  logic [NUM_CH-1:0][31:0]       ch_rdata;
  pio_counter_pkg::ch_req_t [NUM_CH-1:0] req;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    localparam logic [31:0] BASE = 32'h10 + 32'(8 * n);
    assign sel[n]       = (pio_addr[31:3] == BASE[31:3]);
    assign req[n].we    = pio_hwen && sel[n];
    assign req[n].off   = pio_addr[2:0];
    assign req[n].wdata = pio_wdata;

    pio_counter_ch #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .req      (req[n]),
      .gen      (gen),
      .done_clr (pio_hwen && (pio_addr == 32'd1) && pio_wdata[n]),
      .cnt      (count[n]),
      .done     (done[n]),
      .rdata    (ch_rdata[n])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset)                                gen <= 1'b1;
    else if (pio_hwen && pio_addr == 32'd2)    gen <= pio_wdata[0];
  end

  always_comb begin
    pio_rdata = '0;
    if (pio_addr == 32'd0)      pio_rdata = SERIAL;
    else if (pio_addr == 32'd1) pio_rdata = 32'(done);
    else if (pio_addr == 32'd2) pio_rdata = {31'b0, gen};
    for (int n = 0; n < NUM_CH; n++)
      if (sel[n]) pio_rdata = ch_rdata[n];
  end

  assign finished             = |done;
  assign led                  = count[0][LED_BIT];
  assign design_serial_number = SERIAL;
endmodule

// File: tb/tb_pio_counter_bank.sv
// Randomised bench for pio_counter_bank against a per-channel arithmetic model,
// plus directed sequences with hand-computed values.
module tb_pio_counter_bank;
  localparam int W   = 40;
  localparam int NCH = 4;
  localparam int LB  = 26;
  localparam logic [31:0] SER = 32'h0022_1103;
  localparam longint unsigned MASK = (64'd1 << W) - 1;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     pio_hwen = 1'b0;
  logic [31:0]              pio_addr = '0;
  logic [31:0]              pio_wdata = '0;
  logic [31:0]              pio_rdata;
  logic [NCH-1:0][W-1:0]    count;
  logic                     finished, led;
  logic [31:0]              design_serial_number;

  pio_counter_bank #(.WIDTH(W), .NUM_CH(NCH), .LED_BIT(LB), .SERIAL(SER)) dut (
    .clk(clk), .reset(reset), .pio_hwen(pio_hwen), .pio_addr(pio_addr),
    .pio_wdata(pio_wdata), .pio_rdata(pio_rdata), .count(count),
    .finished(finished), .led(led), .design_serial_number(design_serial_number)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain per-channel state, advanced once per rising edge.
  longint unsigned m_cnt[NCH], m_lim[NCH], m_snap[NCH];
  int unsigned     m_step[NCH];
  bit              m_en[NCH], m_dir[NCH], m_mode[NCH], m_done[NCH];
  bit              m_gen;

  function automatic int chan_of(input logic [31:0] a);
    if (a >= 32'h10 && a < 32'h10 + 8 * NCH) return int'((a - 32'h10) / 8);
    return -1;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    int n;
    logic [31:0] s;
    if (a == 0) return SER;
    if (a == 1) begin
      s = '0;
      for (int i = 0; i < NCH; i++) s[i] = m_done[i];
      return s;
    end
    if (a == 2) return {31'b0, m_gen};
    n = chan_of(a);
    if (n < 0) return '0;
    case (a % 8)
      0: return {29'b0, m_mode[n], m_dir[n], m_en[n]};
      1: return m_lim[n][31:0];
      2: return m_lim[n][63:32];
      3: return m_step[n];
      5: return m_snap[n][31:0];
      6: return m_snap[n][63:32];
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    longint unsigned pre, nx;
    bit wr_here, clr, term;
    int ch;
    if (!reset) begin
      for (int n = 0; n < NCH; n++) begin
        m_cnt[n] = 0; m_snap[n] = 0; m_done[n] = 0; m_lim[n] = MASK; m_step[n] = 1;
        m_en[n] = 1; m_dir[n] = 0; m_mode[n] = 0;
      end
      m_gen = 1;
    end else begin
      ch = pio_hwen ? chan_of(pio_addr) : -1;
      for (int n = 0; n < NCH; n++) begin
        pre = m_cnt[n];
        nx = pre;
        term = 0;
        wr_here = (ch == n);
        clr = wr_here && (pio_addr % 8 == 0) && pio_wdata[3];
        if (clr) nx = 0;
        else if (m_gen && m_en[n]) begin
          if (!m_dir[n]) begin
            if (pre >= m_lim[n]) begin term = 1; nx = m_mode[n] ? pre : 0; end
            else nx = (pre + m_step[n] > m_lim[n]) ? m_lim[n] : pre + m_step[n];
          end else begin
            if (pre == 0) begin term = 1; nx = m_mode[n] ? 0 : m_lim[n]; end
            else nx = (pre < m_step[n]) ? 0 : pre - m_step[n];
          end
        end
        if (pio_hwen && pio_addr == 1 && pio_wdata[n]) m_done[n] = 0;
        if (term) m_done[n] = 1;
        m_cnt[n] = nx;
        if (wr_here) begin
          case (pio_addr % 8)
            0: begin m_en[n] = pio_wdata[0]; m_dir[n] = pio_wdata[1]; m_mode[n] = pio_wdata[2]; end
            1: m_lim[n] = ((m_lim[n] >> 32) << 32 | 64'(pio_wdata)) & MASK;
            2: m_lim[n] = ((64'(pio_wdata) << 32) | (m_lim[n] & 64'hFFFF_FFFF)) & MASK;
            3: m_step[n] = pio_wdata;
            4: m_snap[n] = pre;
            default: ;
          endcase
        end
      end
      if (pio_hwen && pio_addr == 2) m_gen = pio_wdata[0];
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      bit any;
      any = 0;
      for (int n = 0; n < NCH; n++) begin
        chk($sformatf("count%0d", n), 64'(count[n]), m_cnt[n]);
        any |= m_done[n];
      end
      chk("finished", 64'(finished), 64'(any));
      chk("led", 64'(led), 64'(m_cnt[0][LB]));
      chk($sformatf("rdata@%h", pio_addr), 64'(pio_rdata), 64'(mread(pio_addr)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    pio_hwen = 1; pio_addr = a; pio_wdata = d;
    tick();
    pio_hwen = 0; pio_addr = '0; pio_wdata = '0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    pio_addr = a;
    #1;
    chk(name, 64'(pio_rdata), 64'(exp));
  endtask

  initial begin
    longint unsigned e_snap, e3;
    int k, off, n;
    logic [31:0] a, d;
    int c1[5] = '{3, 6, 9, 10, 10};

    repeat (3) tick();
    chk_on = 1;
    for (int i = 0; i < NCH; i++) chk("reset_count", 64'(count[i]), 64'd0);
    chk("reset_finished", 64'(finished), 64'd0);
    rd_chk("id", 32'h0, 32'h0022_1103);
    chk("serial", 64'(design_serial_number), 64'h0022_1103);
    reset = 1;
    tick();
    for (int i = 0; i < NCH; i++) chk("first_count", 64'(count[i]), 64'd1);
    tick();
    for (int i = 0; i < NCH; i++) chk("second_count", 64'(count[i]), 64'd2);

    // Ch1: stop at 10, step 3
    wr(32'h18, 32'h4);
    wr(32'h19, 32'd10);
    wr(32'h1A, 32'd0);
    wr(32'h1B, 32'd3);
    wr(32'h18, 32'hD);
    chk("ch1_clr", 64'(count[1]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ch1_seq", 64'(count[1]), 64'(c1[i]));
    end
    rd_chk("ch1_status_pre", 32'h1, 32'h0);
    tick();
    chk("ch1_hold", 64'(count[1]), 64'd10);
    rd_chk("ch1_status_set", 32'h1, 32'h2);
    chk("ch1_finished", 64'(finished), 64'd1);
    wr(32'h1, 32'h2);
    rd_chk("ch1_set_wins", 32'h1, 32'h2);
    wr(32'h18, 32'h0);
    wr(32'h1, 32'h2);
    rd_chk("ch1_cleared", 32'h1, 32'h0);

    // Ch2: down, wrap, limit 5, step 2
    wr(32'h20, 32'h0);
    wr(32'h21, 32'd5);
    wr(32'h22, 32'd0);
    wr(32'h23, 32'd2);
    wr(32'h20, 32'hB);
    chk("ch2_clr", 64'(count[2]), 64'd0);
    tick();
    chk("ch2_wrap1", 64'(count[2]), 64'd5);
    rd_chk("ch2_done1", 32'h1, 32'h4);
    wr(32'h1, 32'h4);
    chk("ch2_3", 64'(count[2]), 64'd3);
    rd_chk("ch2_w1c", 32'h1, 32'h0);
    tick(); chk("ch2_1", 64'(count[2]), 64'd1);
    tick(); chk("ch2_0", 64'(count[2]), 64'd0);
    tick(); chk("ch2_wrap2", 64'(count[2]), 64'd5);
    rd_chk("ch2_done2", 32'h1, 32'h4);
    wr(32'h20, 32'h0);
    wr(32'h1, 32'h4);

    // Ch0 snapshot
    e_snap = m_cnt[0];
    wr(32'h14, 32'h0);
    repeat (20) tick();
    rd_chk("snap_lo", 32'h15, e_snap[31:0]);
    rd_chk("snap_hi", 32'h16, e_snap[63:32]);

    // Global freeze, then reset mid-count
    wr(32'h2, 32'h0);
    e3 = m_cnt[3];
    repeat (3) tick();
    chk("freeze_ch3", 64'(count[3]), e3);
    rd_chk("gen_off", 32'h2, 32'h0);
    reset = 0;
    tick();
    for (int i = 0; i < NCH; i++) chk("rst_count", 64'(count[i]), 64'd0);
    reset = 1;
    rd_chk("rst_lim_lo", 32'h19, 32'hFFFF_FFFF);
    rd_chk("rst_lim_hi", 32'h1A, 32'h0000_00FF);
    rd_chk("rst_step", 32'h1B, 32'h1);
    rd_chk("rst_gen", 32'h2, 32'h1);
    rd_chk("rst_ctrl", 32'h18, 32'h1);

    // Unmapped access and WIDTH masking on LIMIT_HI
    rd_chk("unmapped_rd", 32'h7F, 32'h0);
    wr(32'h7F, 32'hFFFF_FFFF);
    rd_chk("unmapped_wr", 32'h7F, 32'h0);
    wr(32'h12, 32'h0);
    rd_chk("limhi_zero", 32'h12, 32'h0);
    wr(32'h12, 32'hFFFF_FFFF);
    rd_chk("limhi_mask", 32'h12, 32'h0000_00FF);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) >= 2);
      pio_hwen = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 9);
      d = $urandom;
      if (k == 0) a = 32'h1;
      else if (k == 1) begin a = 32'h2; d = {31'b0, ($urandom_range(0, 3) != 0)}; end
      else if (k == 2) a = 32'h7F;
      else if (k == 3) a = $urandom;
      else begin
        n = $urandom_range(0, NCH - 1);
        off = $urandom_range(0, 7);
        a = 32'h10 + 32'(8 * n + off);
        case (off)
          0: d = 32'($urandom_range(0, 7)) | (($urandom_range(0, 9) == 0) ? 32'h8 : 32'h0)
                 | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
          1: d = $urandom_range(0, 40);
          2: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
          3: d = $urandom_range(0, 7);
          default: ;
        endcase
      end
      pio_addr = a;
      pio_wdata = d;
      tick();
    end
    pio_hwen = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
